// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents:
//   - register offsets inside the 16-byte window
//   - bit positions of the STATUS register
//   - the transmit FSM state type
package uart_mmio_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_BAUD   = 4'h8;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head.
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears pointers only)
//   push/wdata : write request and data; accepted when not full or when a
//                pop happens on the same edge
//   pop/rdata  : read request and current head entry
//   full/empty/count : occupancy flags and entry count
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter sitting beside the data memory.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   memwrite   : store strobe from the core
//   addr, wd   : byte address and store data from the core
//   rd         : combinational read data (0 when not addressed)
//   hit        : addr falls inside the 16-byte register window
//   tx         : registered serial output, idle high
module uart_tx_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] CLKS_PER_BIT = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic        tx
);

  // A divisor of zero is treated as one cycle per bit.
  function automatic logic [15:0] eff_period(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

  tx_state_e   state;
  logic [15:0] baud_div;
  logic [15:0] period;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        overflow;

  logic [3:0]  off;
  logic        wr_txdata, wr_status, wr_baud;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic        bit_end;
  logic        busy;
  logic        unused_bits;

  assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign off       = {addr[3:2], 2'b00};
  assign wr_txdata = memwrite && hit && (off == OFF_TXDATA);
  assign wr_status = memwrite && hit && (off == OFF_STATUS);
  assign wr_baud   = memwrite && hit && (off == OFF_BAUD);
  assign busy      = (state != ST_IDLE);
  assign bit_end   = (baud_cnt == period - 16'd1);

  // The head leaves the FIFO when the FSM starts a frame, either from idle
  // or straight out of the final stop-bit cycle.
  assign fifo_pop  = !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
  assign fifo_push = wr_txdata && (!fifo_full || fifo_pop);

  assign unused_bits = ^{addr[1:0], wd[31:16], fifo_count};

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (wd[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rd = 32'd0;
    if (hit) begin
      case (off)
        OFF_STATUS: begin
          rd[STAT_BUSY]  = busy;
          rd[STAT_FULL]  = fifo_full;
          rd[STAT_EMPTY] = fifo_empty;
          rd[STAT_OVF]   = overflow;
        end
        OFF_BAUD: rd = {16'd0, baud_div};
        default:  rd = 32'd0;
      endcase
    end
  end

  // A dropped byte wins over a same-edge W1C clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_div <= CLKS_PER_BIT;
      overflow <= 1'b0;
    end else begin
      if (wr_baud) baud_div <= wd[15:0];
      if (wr_txdata && !fifo_push)             overflow <= 1'b1;
      else if (wr_status && wd[STAT_OVF])      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (fifo_pop) begin
            shift    <= fifo_head;
            period   <= eff_period(baud_div);
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            tx       <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            tx       <= shift[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            if (fifo_pop) begin
              shift   <= fifo_head;
              period  <= eff_period(baud_div);
              bit_idx <= 3'd0;
              tx      <= 1'b0;
              state   <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed register/boundary steps
// plus randomized frames compared against a waveform model of 8N1 framing.
module tb_uart_tx_mmio;

  localparam logic [31:0] ADDR_TX = 32'h0000_1000;
  localparam logic [31:0] ADDR_ST = 32'h0000_1004;
  localparam logic [31:0] ADDR_BD = 32'h0000_1008;
  localparam logic [31:0] ADDR_RS = 32'h0000_100C;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        hit;
  logic        tx;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] sent_q[$];

  uart_tx_mmio #(
    .BASE_ADDR    (32'h0000_1000),
    .FIFO_DEPTH   (4),
    .CLKS_PER_BIT (16'd16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .addr     (addr),
    .wd       (wd),
    .rd       (rd),
    .hit      (hit),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One store on the next rising edge; leaves the bus pointing at STATUS.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1;
    addr     = a;
    wd       = d;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    addr     = ADDR_ST;
    wd       = 32'd0;
  endtask

  // Expected line level c cycles after the first frame starts, for
  // back-to-back frames of the bytes in sent_q with p cycles per bit.
  function automatic logic exp_tx(input int p, input int c);
    int frame, slot;
    frame = c / (10 * p);
    slot  = (c % (10 * p)) / p;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return sent_q[frame][slot-1];
  endfunction

  // Started together with the first write: follows that write's edge and
  // checks every following cycle against the model.
  task automatic check_wave(input int p, input string tag);
    int n;
    n = sent_q.size() * 10 * p;
    @(posedge clk);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #2;
      chk(tag, {31'd0, tx}, {31'd0, exp_tx(p, c)});
      if (!memwrite && addr == ADDR_ST)
        chk({tag, "_busy"}, {31'd0, rd[0]}, 32'd1);
    end
    @(posedge clk);
    #2;
    chk({tag, "_idle_tx"}, {31'd0, tx}, 32'd1);
    chk({tag, "_idle_status"}, rd, 32'h4);
  endtask

  initial begin
    int b, nb, p;
    logic [31:0] junk;

    reset    = 1'b1;
    memwrite = 1'b0;
    addr     = 32'd0;
    wd       = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state and register decode
    addr = ADDR_ST; #1;
    chk("rst_status", rd, 32'h4);
    chk("rst_hit", {31'd0, hit}, 32'd1);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    addr = 32'h0000_1007; #1;
    chk("status_unaligned", rd, 32'h4);
    addr = ADDR_TX; #1;
    chk("txdata_reads0", rd, 32'd0);
    addr = ADDR_BD; #1;
    chk("rst_baud", rd, 32'd16);
    addr = 32'h0000_2000; #1;
    chk("miss_hit", {31'd0, hit}, 32'd0);
    chk("miss_rd", rd, 32'd0);
    addr = 32'h0000_2008; #1;
    chk("miss_rd_baudoff", rd, 32'd0);
    wr(ADDR_RS, 32'hFFFF_FFFF);
    addr = ADDR_RS; #1;
    chk("reserved_rd", rd, 32'd0);
    addr = ADDR_BD; #1;
    chk("baud_after_reserved", rd, 32'd16);
    wr(32'h0000_2000, 32'h55);
    wr(32'h0000_2008, 32'h3);
    repeat (3) @(posedge clk);
    #1;
    chk("miss_write_tx", {31'd0, tx}, 32'd1);
    chk("miss_write_status", rd, 32'h4);
    addr = ADDR_BD; #1;
    chk("miss_write_baud", rd, 32'd16);
    addr = ADDR_ST;

    // Single frame, 4 cycles per bit
    wr(ADDR_BD, 32'd4);
    sent_q = '{8'h55};
    fork
      wr(ADDR_TX, 32'h55);
      check_wave(4, "frame55");
    join

    // Back-to-back frames with no idle gap
    sent_q = '{8'h41, 8'h42};
    fork
      begin
        wr(ADDR_TX, 32'h41);
        wr(ADDR_TX, 32'h42);
      end
      check_wave(4, "b2b");
    join

    // Overflow: six writes, the sixth dropped, then W1C clear
    sent_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    fork
      begin
        for (int k = 1; k <= 6; k++) wr(ADDR_TX, k);
        #1;
        chk("ovf_status", rd, 32'hB);
        wr(ADDR_ST, 32'h8);
        #1;
        chk("ovf_cleared", rd, 32'h3);
      end
      check_wave(4, "ovf");
    join

    // Divisor zero behaves as one cycle per bit
    wr(ADDR_BD, 32'd0);
    addr = ADDR_BD; #1;
    chk("baud_zero_rd", rd, 32'd0);
    addr = ADDR_ST;
    sent_q = '{8'hFF};
    fork
      wr(ADDR_TX, 32'hFF);
      check_wave(1, "div0");
    join

    // Randomized divisors and byte bursts
    for (int t = 0; t < 5; t++) begin
      b  = $urandom_range(0, 5);
      nb = $urandom_range(1, 3);
      p  = (b == 0) ? 1 : b;
      wr(ADDR_BD, b);
      addr = ADDR_BD; #1;
      chk("rand_baud_rd", rd, b);
      addr = ADDR_ST;
      sent_q.delete();
      for (int k = 0; k < nb; k++) sent_q.push_back(8'($urandom));
      fork
        begin
          for (int k = 0; k < nb; k++) begin
            junk = $urandom;
            wr(ADDR_TX, {junk[31:8], sent_q[k]});
          end
        end
        check_wave(p, "rand");
      join
    end

    // Reset mid-frame with bytes still queued
    wr(ADDR_BD, 32'd4);
    wr(ADDR_TX, 32'hAA);
    wr(ADDR_TX, 32'hBB);
    wr(ADDR_TX, 32'hCC);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_reset_busy", {31'd0, rd[0]}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("post_reset_tx", {31'd0, tx}, 32'd1);
    chk("post_reset_status", rd, 32'h4);
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #2;
      chk("post_reset_quiet", {31'd0, tx}, 32'd1);
    end
    chk("post_reset_status_end", rd, 32'h4);
    addr = ADDR_BD; #1;
    chk("post_reset_baud", rd, 32'd16);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
